// File: rtl/zap_interrupt_controller.sv
// zap_interrupt_controller
//   Vectored interrupt front end for the ZAP register file. It detects rising
//   edges on i_src into PENDING, then qualifies them with ENABLE, FIQ_SEL and
//   the CPSR I/F masks. It raises o_irq / o_fiq, each with a frozen source ID,
//   and holds the request until the register file acknowledges it.
// Ports:
//   i_clk, i_reset_n          clock, synchronous active-low reset
//   i_src[NUM_SOURCES]        interrupt lines (rising edge = request)
//   i_cpsr[32]                CPSR; bit 7 = I mask, bit 6 = F mask
//   i_cfg_wr_en/addr/wr_data  config write: 0 ENABLE, 1 FIQ_SEL, 2 PENDING(RO), 3 CLEAR(WO)
//   o_cfg_rd_data[32]         combinational read of i_cfg_addr
//   o_irq/o_irq_id, o_fiq/o_fiq_id   registered requests + serviced source ID
//   i_irq_ack, i_fiq_ack      acknowledges from the register file

// One request channel (IRQ or FIQ): IDLE -> REQ -> GAP handshake.
module zap_intc_chan #(
  parameter int NUM_SOURCES = 8,
  parameter int IDW         = $clog2(NUM_SOURCES),
  parameter bit IS_FIQ      = 1'b0
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic [NUM_SOURCES-1:0] i_cand,
  input  logic                   i_mask,
  input  logic                   i_ack,
  input  logic [NUM_SOURCES-1:0] i_en,
  input  logic [NUM_SOURCES-1:0] i_fsel,
  output logic                   o_req,
  output logic [IDW-1:0]         o_id,
  output logic [NUM_SOURCES-1:0] o_clr
);
  typedef enum logic [1:0] {IDLE, REQ, GAP} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] id_q, id_d, win;

  // Lowest index wins: scan downward so the last hit is the smallest index.
  always_comb begin
    win = '0;
    for (int i = NUM_SOURCES-1; i >= 0; i--)
      if (i_cand[i]) win = IDW'(i);
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    o_clr   = '0;
    case (state_q)
      // GAP holds the output low for one cycle and then behaves like IDLE,
      // so a still-pending source can re-request two cycles after the ack.
      IDLE, GAP: begin
        if (|i_cand && !i_mask) begin
          state_d = REQ;
          id_d    = win;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (i_ack) begin
          o_clr[id_q] = 1'b1;
          state_d     = GAP;
        end else if (i_mask || !i_en[id_q] || (i_fsel[id_q] != IS_FIQ)) begin
          // Withdrawn: PENDING is left intact so it is serviced later.
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
    end
  end

  assign o_req = (state_q == REQ);
  assign o_id  = id_q;
endmodule

module zap_interrupt_controller #(
  parameter int NUM_SOURCES = 8,
  parameter int IDW         = $clog2(NUM_SOURCES)
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic [NUM_SOURCES-1:0] i_src,
  input  logic [31:0]            i_cpsr,
  input  logic                   i_cfg_wr_en,
  input  logic [1:0]             i_cfg_addr,
  input  logic [31:0]            i_cfg_wr_data,
  output logic [31:0]            o_cfg_rd_data,
  output logic                   o_irq,
  output logic                   o_fiq,
  output logic [IDW-1:0]         o_irq_id,
  output logic [IDW-1:0]         o_fiq_id,
  input  logic                   i_irq_ack,
  input  logic                   i_fiq_ack
);
  localparam int N = NUM_SOURCES;

  logic [N-1:0] src_q, pend_q, pend_d, en_q, en_d, fsel_q, fsel_d;
  logic [N-1:0] edge_det, cfg_clr, irq_clr, fiq_clr, irq_cand, fiq_cand;
  logic [N-1:0] wdata;
  logic         unused_ok;

  assign wdata     = i_cfg_wr_data[N-1:0];
  assign unused_ok = ^{i_cpsr, i_cfg_wr_data};
  assign edge_det  = i_src & ~src_q;
  assign cfg_clr   = (i_cfg_wr_en && i_cfg_addr == 2'd3) ? wdata : '0;

  always_comb begin
    en_d   = en_q;
    fsel_d = fsel_q;
    if (i_cfg_wr_en && i_cfg_addr == 2'd0) en_d   = wdata;
    if (i_cfg_wr_en && i_cfg_addr == 2'd1) fsel_d = wdata;
    // A new edge wins over any clear in the same cycle.
    pend_d = (pend_q & ~cfg_clr & ~irq_clr & ~fiq_clr) | edge_det;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      src_q  <= i_src;  // lines already high at reset exit are not edges
      pend_q <= '0;
      en_q   <= '0;
      fsel_q <= '0;
    end else begin
      src_q  <= i_src;
      pend_q <= pend_d;
      en_q   <= en_d;
      fsel_q <= fsel_d;
    end
  end

  assign irq_cand = pend_q & en_q & ~fsel_q;
  assign fiq_cand = pend_q & en_q &  fsel_q;

  zap_intc_chan #(.NUM_SOURCES(N), .IDW(IDW), .IS_FIQ(1'b0)) u_irq (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_cand(irq_cand), .i_mask(i_cpsr[7]),
    .i_ack(i_irq_ack), .i_en(en_q), .i_fsel(fsel_q),
    .o_req(o_irq), .o_id(o_irq_id), .o_clr(irq_clr)
  );

  zap_intc_chan #(.NUM_SOURCES(N), .IDW(IDW), .IS_FIQ(1'b1)) u_fiq (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_cand(fiq_cand), .i_mask(i_cpsr[6]),
    .i_ack(i_fiq_ack), .i_en(en_q), .i_fsel(fsel_q),
    .o_req(o_fiq), .o_id(o_fiq_id), .o_clr(fiq_clr)
  );

  always_comb begin
    o_cfg_rd_data = '0;
    case (i_cfg_addr)
      2'd0:    o_cfg_rd_data[N-1:0] = en_q;
      2'd1:    o_cfg_rd_data[N-1:0] = fsel_q;
      2'd2:    o_cfg_rd_data[N-1:0] = pend_q;
      default: o_cfg_rd_data = '0;
    endcase
  end
endmodule

// File: tb/tb_zap_interrupt_controller.sv
module tb_zap_interrupt_controller;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  src;
  logic [31:0] cpsr;
  logic        wr_en;
  logic [1:0]  addr;
  logic [31:0] wdata, rdata;
  logic        irq, fiq, irq_ack, fiq_ack;
  logic [2:0]  irq_id, fiq_id;

  int checks = 0;
  int passed = 0;

  zap_interrupt_controller #(.NUM_SOURCES(8)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_src(src), .i_cpsr(cpsr),
    .i_cfg_wr_en(wr_en), .i_cfg_addr(addr), .i_cfg_wr_data(wdata),
    .o_cfg_rd_data(rdata), .o_irq(irq), .o_fiq(fiq),
    .o_irq_id(irq_id), .o_fiq_id(fiq_id),
    .i_irq_ack(irq_ack), .i_fiq_ack(fiq_ack)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    addr = a; #1; v = rdata;
  endtask

  task automatic chk_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] v;
    rd(a, v);
    chk(tag, v, exp);
  endtask

  task automatic cfg_wr(input logic [1:0] a, input logic [31:0] d);
    wr_en = 1'b1; addr = a; wdata = d;
    tick();
    wr_en = 1'b0; wdata = '0;
  endtask

  task automatic pulse(input logic [7:0] s);
    src = s; tick(); src = '0;
  endtask

  task automatic ack_irq;
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
  endtask

  // Bounded wait for o_irq; timing out shows up as a failed check.
  task automatic wait_irq(input string tag, input logic [2:0] exp_id);
    for (int i = 0; i < 6 && !irq; i++) tick();
    chk({tag, "_irq"}, {31'd0, irq}, 32'd1);
    chk({tag, "_id"}, {29'd0, irq_id}, {29'd0, exp_id});
  endtask

  initial begin
    rst_n = 1'b0; src = 8'hFF; cpsr = '0; wr_en = 1'b0; addr = '0; wdata = '0;
    irq_ack = 1'b0; fiq_ack = 1'b0;
    tick(3);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_fiq", {31'd0, fiq}, 32'd0);
    chk("rst_ids", {26'd0, irq_id, fiq_id}, 32'd0);
    chk_rd("rst_enable", 2'd0, 32'd0);
    chk_rd("rst_fiqsel", 2'd1, 32'd0);

    // Lines high across reset release are not edges.
    rst_n = 1'b1;
    tick(2);
    chk_rd("held_high_pend", 2'd2, 32'd0);
    src = '0; tick();
    chk_rd("fall_pend", 2'd2, 32'd0);

    // Basic IRQ on source 0: PENDING after 1 edge, o_irq after 2.
    cfg_wr(2'd0, 32'h01);
    chk_rd("enable_rd", 2'd0, 32'h01);
    cfg_wr(2'd2, 32'hFF);
    chk_rd("pend_wr_ignored", 2'd2, 32'h00);
    pulse(8'h01);
    chk_rd("basic_pend", 2'd2, 32'h01);
    chk("basic_irq_early", {31'd0, irq}, 32'd0);
    tick();
    chk("basic_irq", {31'd0, irq}, 32'd1);
    chk("basic_id", {29'd0, irq_id}, 32'd0);
    tick(2);
    chk("basic_hold", {31'd0, irq}, 32'd1);
    ack_irq();
    chk("basic_gap", {31'd0, irq}, 32'd0);
    chk_rd("basic_pend_clr", 2'd2, 32'h00);
    chk_rd("clear_reads0", 2'd3, 32'h00);
    tick();
    chk("basic_idle", {31'd0, irq}, 32'd0);

    // Priority and ID freeze.
    cfg_wr(2'd0, 32'hFF);
    pulse(8'h24);
    tick();
    chk("prio_id2", {29'd0, irq_id}, 32'd2);
    chk("prio_irq", {31'd0, irq}, 32'd1);
    ack_irq();
    chk("prio_gap", {31'd0, irq}, 32'd0);
    wait_irq("prio_next", 3'd5);
    pulse(8'h02);
    tick();
    chk_rd("freeze_pend", 2'd2, 32'h22);
    chk("freeze_id", {29'd0, irq_id}, 32'd5);
    ack_irq();
    wait_irq("prio_last", 3'd1);
    ack_irq();
    tick(2);
    chk("prio_done", {31'd0, irq}, 32'd0);
    chk_rd("prio_pend", 2'd2, 32'h00);

    // Concurrent IRQ (source 0) and FIQ (source 7).
    cfg_wr(2'd1, 32'h80);
    cfg_wr(2'd0, 32'h81);
    pulse(8'h81);
    tick();
    chk("dual_irq", {31'd0, irq}, 32'd1);
    chk("dual_fiq", {31'd0, fiq}, 32'd1);
    chk("dual_ids", {26'd0, irq_id, fiq_id}, {26'd0, 3'd0, 3'd7});
    fiq_ack = 1'b1; tick(); fiq_ack = 1'b0;
    chk("dual_fiq_gap", {31'd0, fiq}, 32'd0);
    chk("dual_irq_hold", {31'd0, irq}, 32'd1);
    chk_rd("dual_pend", 2'd2, 32'h01);
    ack_irq();
    chk("dual_irq_gap", {31'd0, irq}, 32'd0);
    chk_rd("dual_pend_clr", 2'd2, 32'h00);

    // Withdrawal by I mask keeps PENDING.
    cfg_wr(2'd1, 32'h00);
    cfg_wr(2'd0, 32'h08);
    pulse(8'h08);
    tick();
    chk("mask_irq_id3", {28'd0, irq, irq_id}, {28'd0, 1'b1, 3'd3});
    cpsr = 32'h80; tick();
    chk("mask_withdraw", {31'd0, irq}, 32'd0);
    chk_rd("mask_pend_kept", 2'd2, 32'h08);
    tick(2);
    chk("mask_stays_low", {31'd0, irq}, 32'd0);
    cpsr = '0;
    wait_irq("mask_reassert", 3'd3);
    ack_irq();
    tick(2);

    // Set beats CLEAR write; edge together with ack re-requests.
    cfg_wr(2'd0, 32'h00);
    src = 8'h04; wr_en = 1'b1; addr = 2'd3; wdata = 32'h04;
    tick();
    src = '0; wr_en = 1'b0; wdata = '0;
    chk_rd("set_beats_clear", 2'd2, 32'h04);
    cfg_wr(2'd3, 32'h04);
    chk_rd("clear_works", 2'd2, 32'h00);
    cfg_wr(2'd0, 32'h04);
    pulse(8'h04);
    tick();
    chk("edge_ack_req", {28'd0, irq, irq_id}, {28'd0, 1'b1, 3'd2});
    src = 8'h04; irq_ack = 1'b1; tick(); src = '0; irq_ack = 1'b0;
    chk("edge_ack_gap", {31'd0, irq}, 32'd0);
    chk_rd("edge_ack_pend", 2'd2, 32'h04);
    wait_irq("edge_ack_again", 3'd2);
    ack_irq();
    tick();

    // Reset during an FIQ request, with an ack in flight.
    cfg_wr(2'd1, 32'h80);
    cfg_wr(2'd0, 32'h80);
    pulse(8'h80);
    tick();
    chk("rst_mid_fiq", {28'd0, fiq, fiq_id}, {28'd0, 1'b1, 3'd7});
    rst_n = 1'b0; fiq_ack = 1'b1;
    tick();
    chk("rst_mid_outs", {24'd0, irq, fiq, irq_id, fiq_id}, 32'd0);
    chk_rd("rst_mid_pend", 2'd2, 32'h00);
    chk_rd("rst_mid_en", 2'd0, 32'h00);
    rst_n = 1'b1; fiq_ack = 1'b0;
    tick(3);
    chk("post_rst_fiq", {31'd0, fiq}, 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
